// File: rtl/withdraw_ctrl.sv
// Withdrawal controller: owns the account balance, credits deposit pulses,
// and checks each withdraw press against available funds before debiting
// or raising a timed deny indication.
module withdraw_ctrl #(
  parameter int unsigned BAL_W       = 8,
  parameter int unsigned DEP_STEP    = 1,
  parameter int unsigned WD_STEP     = 1,
  parameter int unsigned DENY_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_up,
  input  logic             Down_Button,
  output logic [BAL_W-1:0] balance,
  output logic             count_down,
  output logic             deny,
  output logic             full
);

  localparam int unsigned CntW = (DENY_CYCLES > 1) ? $clog2(DENY_CYCLES) : 1;

  localparam logic [BAL_W:0]  MaxBal   = {1'b0, {BAL_W{1'b1}}};
  localparam logic [BAL_W:0]  DepAmt   = (BAL_W + 1)'(DEP_STEP);
  localparam logic [BAL_W:0]  WdAmt    = (BAL_W + 1)'(WD_STEP);
  localparam logic [CntW-1:0] DenyLoad = CntW'(DENY_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDebit,
    StDeny,
    StWaitRel
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [BAL_W:0]   sum;
  logic             debit;

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_down = 1'b0;
    deny       = 1'b0;
    debit      = 1'b0;
    case (state_q)
      StIdle: begin
        if (Down_Button) state_d = StCheck;
      end
      StCheck: begin
        // Decision uses the registered balance only; same-cycle credits wait.
        if ({1'b0, bal_q} >= WdAmt) begin
          state_d = StDebit;
        end else begin
          state_d = StDeny;
          cnt_d   = DenyLoad;
        end
      end
      StDebit: begin
        count_down = 1'b1;
        debit      = 1'b1;
        state_d    = StWaitRel;
      end
      StDeny: begin
        deny = 1'b1;
        if (cnt_q == '0) begin
          state_d = StWaitRel;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitRel: begin
        if (!Down_Button) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Balance update: credit and debit combined in one edge, saturating at the top.
  always_comb begin
    sum = {1'b0, bal_q} + (count_up ? DepAmt : '0) - (debit ? WdAmt : '0);
    if (sum > MaxBal) begin
      bal_d = {BAL_W{1'b1}};
    end else begin
      bal_d = sum[BAL_W-1:0];
    end
  end

  // State, deny counter and balance registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bal_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bal_q   <= bal_d;
    end
  end

  assign balance = bal_q;
  assign full    = (bal_q == {BAL_W{1'b1}});

endmodule

// File: tb/tb_withdraw_ctrl.sv
// Testbench: a default-width instance and a 4-bit instance share stimulus and are
// each checked every cycle against a press-timeline reference model.
module tb_withdraw_ctrl;

  localparam int Dep = 1;
  localparam int Wd  = 1;
  localparam int Dc  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cu = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] bal_a;
  logic [3:0] bal_b;
  logic       cd_a, cd_b, dn_a, dn_b, fu_a, fu_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles elapsed since an accepted press, plus the outcome.
  int m_bal[2];
  int m_age[2];
  bit m_grant[2];
  bit m_wait[2];
  int maxb[2] = '{255, 15};
  int n_cd[2];
  int n_dn[2];

  withdraw_ctrl dut_a (
    .clk        (clk),
    .reset      (reset),
    .count_up   (cu),
    .Down_Button(btn),
    .balance    (bal_a),
    .count_down (cd_a),
    .deny       (dn_a),
    .full       (fu_a)
  );

  withdraw_ctrl #(.BAL_W(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .count_up   (cu),
    .Down_Button(btn),
    .balance    (bal_b),
    .count_down (cd_b),
    .deny       (dn_b),
    .full       (fu_b)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset(int k);
    m_bal[k]   = 0;
    m_age[k]   = 0;
    m_grant[k] = 1'b0;
    m_wait[k]  = 1'b0;
  endtask

  task automatic mupdate(int k);
    bit debit_now;
    int nb;
    debit_now = m_grant[k] && (m_age[k] == 2);
    nb = m_bal[k] + (cu ? Dep : 0) - (debit_now ? Wd : 0);
    if (nb > maxb[k]) nb = maxb[k];
    if (m_wait[k]) begin
      if (!btn) m_wait[k] = 1'b0;
    end else if (m_age[k] == 0) begin
      if (btn) m_age[k] = 1;
    end else begin
      if (m_age[k] == 1) m_grant[k] = (m_bal[k] >= Wd);
      m_age[k]++;
      if ((m_grant[k] && m_age[k] > 2) || (!m_grant[k] && m_age[k] > 1 + Dc)) begin
        m_age[k]  = 0;
        m_wait[k] = 1'b1;
      end
    end
    m_bal[k] = nb;
  endtask

  task automatic step();
    int ob, oc, od, of;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) mreset(k);
      else mupdate(k);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      ob = (k == 0) ? int'(bal_a) : int'(bal_b);
      oc = (k == 0) ? int'(cd_a) : int'(cd_b);
      od = (k == 0) ? int'(dn_a) : int'(dn_b);
      of = (k == 0) ? int'(fu_a) : int'(fu_b);
      n_cd[k] += oc;
      n_dn[k] += od;
      check($sformatf("k%0d balance", k), ob, m_bal[k]);
      check($sformatf("k%0d count_down", k), oc, int'(m_grant[k] && m_age[k] == 2));
      check($sformatf("k%0d deny", k), od, int'(!m_grant[k] && m_age[k] >= 2));
      check($sformatf("k%0d full", k), of, int'(m_bal[k] == maxb[k]));
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin
      n_cd[k] = 0;
      n_dn[k] = 0;
    end
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (3) step();
    btn = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int hold;
    mreset(0);
    mreset(1);
    clr_counts();

    // Reset state.
    repeat (2) step();
    check("rst balance", int'(bal_a), 0);
    check("rst count_down", int'(cd_a), 0);
    check("rst deny", int'(dn_a), 0);
    check("rst full", int'(fu_a), 0);
    reset = 1'b1;
    step();

    // Three credits.
    cu = 1'b1;
    repeat (3) step();
    cu = 1'b0;
    step();
    check("credit3 balance", int'(bal_a), 3);

    // Held button: one debit only.
    clr_counts();
    btn = 1'b1;
    step();
    step();
    check("hold debit cycle2", int'(cd_a), 1);
    repeat (8) step();
    check("hold pulses", n_cd[0], 1);
    check("hold balance", int'(bal_a), 2);
    btn = 1'b0;
    repeat (2) step();

    // Drain to zero, then a denied press.
    press();
    press();
    check("drain balance", int'(bal_a), 0);
    clr_counts();
    btn = 1'b1;
    repeat (8) step();
    check("deny cycles", n_dn[0], 4);
    check("deny no debit", n_cd[0], 0);
    check("deny balance", int'(bal_a), 0);
    cu = 1'b1;
    step();
    cu = 1'b0;
    btn = 1'b0;
    repeat (2) step();
    clr_counts();
    btn = 1'b1;
    repeat (3) step();
    check("retry pulses", n_cd[0], 1);
    check("retry balance", int'(bal_a), 0);
    btn = 1'b0;
    repeat (2) step();

    // Saturation on the 4-bit instance.
    cu = 1'b1;
    repeat (20) step();
    cu = 1'b0;
    step();
    check("sat balance", int'(bal_b), 15);
    check("sat full", int'(fu_b), 1);
    check("wide balance", int'(bal_a), 20);
    press();
    check("sat wd balance", int'(bal_b), 14);
    check("sat wd full", int'(fu_b), 0);

    // Credit coincident with the debit cycle.
    reset = 1'b0;
    step();
    reset = 1'b1;
    cu = 1'b1;
    repeat (5) step();
    cu = 1'b0;
    clr_counts();
    btn = 1'b1;
    step();
    step();
    check("coin debit", int'(cd_a), 1);
    cu = 1'b1;
    step();
    cu = 1'b0;
    check("coin balance", int'(bal_a), 5);
    check("coin balance4", int'(bal_b), 5);
    check("coin pulses", n_cd[0], 1);
    btn = 1'b0;
    repeat (2) step();

    // Async reset in the middle of a deny.
    reset = 1'b0;
    step();
    reset = 1'b1;
    btn = 1'b1;
    step();
    step();
    check("pre-abort deny", int'(dn_a), 1);
    cu = 1'b1;
    step();
    cu = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort deny", int'(dn_a), 0);
    check("abort balance", int'(bal_a), 0);
    check("abort deny4", int'(dn_b), 0);
    mreset(0);
    mreset(1);
    btn = 1'b0;
    step();
    reset = 1'b1;
    step();
    clr_counts();
    btn = 1'b1;
    repeat (3) step();
    check("redeny", int'(dn_a), 1);
    btn = 1'b0;
    repeat (8) step();

    // Randomized traffic.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      cu = ($urandom_range(0, 2) == 0);
      if (hold == 0) begin
        btn  = ~btn;
        hold = $urandom_range(1, 12);
      end
      hold--;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/withdraw_ctrl.md
# withdraw_ctrl

Withdrawal-side controller for the ATM datapath and consumer of the deposit FSM's `count_up` pulse. It owns the account balance register. Deposit pulses credit the balance. Each press of the withdraw button is checked against the current funds and then either debits the balance with a one-cycle `count_down` pulse or raises a timed `deny` indication. Each press is honoured once, and the button must be released before another withdrawal is accepted.

## Interface
- `BAL_W`, 8: balance width in bits; maximum balance `MAX_BAL` = 2^BAL_W − 1.
- `DEP_STEP`, 1: amount credited per `count_up` pulse.
- `WD_STEP`, 1: amount debited per accepted withdrawal; must be ≥ 1 and ≤ `MAX_BAL`.
- `DENY_CYCLES`, 4: number of cycles `deny` is held high; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `count_up`  in  1  one-cycle credit pulse from the deposit FSM, synchronous to `clk`.
- `Down_Button`  in  1  withdraw request level, already synchronised to `clk`.
- `balance`  out  BAL_W  current balance, registered.
- `count_down`  out  1  one-cycle pulse marking an accepted debit.
- `deny`  out  1  high while a withdrawal is being refused for insufficient funds.
- `full`  out  1  high when `balance` == `MAX_BAL`.

## Operation
- States are IDLE, CHECK, DEBIT, DENY and WAIT_REL. Outputs are Moore-decoded from the state.
- IDLE: if `Down_Button` = 1, go to CHECK; otherwise stay in IDLE.
- CHECK: if `balance` ≥ `WD_STEP`, go to DEBIT; otherwise go to DENY. The compare uses the registered balance; a `count_up` arriving in the CHECK cycle is not counted toward this decision.
- DEBIT: `count_down` = 1 for exactly one cycle. The balance is reduced by `WD_STEP` at the end of this cycle. Next state is WAIT_REL.
- DENY: `deny` = 1. A down-counter loaded on entry keeps the FSM in DENY for exactly `DENY_CYCLES` cycles, then goes to WAIT_REL. The balance is unchanged.
- WAIT_REL: stay while `Down_Button` = 1; return to IDLE when it is 0. A held button therefore never produces a second debit.
- Any other state encoding goes to IDLE with all outputs at 0.
- Balance update each cycle computes `balance` + (`count_up` ? `DEP_STEP` : 0) − (DEBIT ? `WD_STEP` : 0):
  - The arithmetic is carried out at BAL_W+1 bits.
  - The result saturates at `MAX_BAL`.
  - It never underflows, because DEBIT is only entered after a successful CHECK and no other path decrements.
- Credits are accepted in every state, including DENY and WAIT_REL.
- `full` is combinational from `balance`.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state = IDLE, `balance` = 0, `count_down` = 0, `deny` = 0, `full` = 0.
  - Asserting reset mid-DEBIT or mid-DENY aborts the operation immediately, with no pending debit.
- Withdraw latency, with `Down_Button` sampled high at edge 0 in IDLE:
  - CHECK during cycle 1.
  - DEBIT (`count_down` high) or the first DENY cycle during cycle 2.
  - New balance visible from cycle 3.
- `deny` is high for cycles 2 through 1+`DENY_CYCLES`, then WAIT_REL.
- Earliest re-acceptance: the button must be seen low for at least one cycle in WAIT_REL, then high again in IDLE.
- Simultaneous credit and debit in the DEBIT cycle: the net change is +`DEP_STEP` − `WD_STEP`, applied in a single edge with saturation.
- Credit at `MAX_BAL`: the balance holds at `MAX_BAL`; `full` stays 1.
- A balance exactly equal to `WD_STEP` is accepted and ends at 0.

## Test plan
- Reset release, then 3 `count_up` pulses (defaults) → `balance` = 3, `count_down` = 0, `deny` = 0.
- Balance 3, hold `Down_Button` high for 10 cycles → exactly one `count_down` pulse, in cycle 2 after the press; `balance` = 2; the FSM stays in WAIT_REL until release.
- Balance 0, press → `deny` high for exactly 4 cycles, no `count_down`, `balance` = 0. Then 1 credit, release, press again → debit, `balance` = 0.
- BAL_W = 4, 20 credits → `balance` saturates at 15, `full` = 1. A withdrawal then gives 14 and `full` = 0.
- Balance 5, `count_up` coincident with the DEBIT cycle → `balance` = 5 on the next cycle; `count_down` still pulses once.
- Assert `reset` low asynchronously between edges during DENY → `deny`, `balance` and the state clear immediately. After release, a press with balance 0 → DENY again.
